alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one combinational ALU, with starvation-bounded priority to requester 0
module alu_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [9:0]        req_aluc_i,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [XLEN-1:0]   rsp_result_o,
  output logic [4:0]        alu_aluc_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  input  logic [XLEN-1:0]   alu_result_i,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic gnt_q;
  logic [4:0] aluc_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic accept, gnt, exec, resp;
  // requester 1 wins only when alone or once requester 0 has used up its starvation allowance
  assign gnt    = (req_valid_i == 2'b10) || (req_valid_i == 2'b11 && starve_q == SMAX);
  assign accept = (state_q == IDLE) && |req_valid_i;
  assign exec   = state_q == EXEC;
  assign resp   = state_q == RESP;
  assign req_ready_o  = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign alu_aluc_o   = exec ? aluc_q : '0;
  assign alu_a_o      = exec ? a_q : '0;
  assign alu_b_o      = exec ? b_q : '0;
  assign rsp_valid_o  = resp ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result_o = resp ? res_q : '0;
  assign busy_o       = state_q != IDLE;
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    state_d  = (state_q == IDLE) ? (accept ? EXEC : IDLE) :
               exec ? RESP : (rsp_ready_i[gnt_q] ? IDLE : RESP);
    starve_d = !accept ? starve_q :
               gnt ? 4'd0 :
               (req_valid_i[1] && starve_q != SMAX) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      starve_q <= '0;
      gnt_q    <= 1'b0;
      aluc_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (accept) begin
        gnt_q  <= gnt;
        aluc_q <= gnt ? req_aluc_i[9:5] : req_aluc_i[4:0];
        a_q    <= gnt ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
        b_q    <= gnt ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
      end
      if (exec) res_q <= alu_result_i;
    end
  end
endmodule
